// File: rtl/mem_access_pkg.sv
// Shared widths, constants and state encodings for the memory-access stage.
package mem_access_pkg;

   localparam int WORD_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int MEM_ADDR_W = 30;
   localparam int MEM_SEL_W  = 4;

   typedef logic [WORD_W-1:0]     word_bus_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
   typedef logic [MEM_ADDR_W-1:0] mem_addr_high_bus_t;
   typedef logic [MEM_SEL_W-1:0]  mem_sel_bus_t;

   // Writeback source select carried down from decode
   localparam logic MEM_SEL_REGVAL = 1'b0;
   localparam logic MEM_SEL_MEMVAL = 1'b1;

   localparam reg_addr_bus_t REG_ZERO  = '0;
   localparam word_bus_t     ZERO_WORD = '0;

   typedef enum logic {
      MEM_STATE_IDLE = 1'b0,
      MEM_STATE_BUSY = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_access_timeout_counter.sv
// Bus-wait watchdog for the memory-access stage. Only instantiated when
// MEM_TIMEOUT_EN is defined. Counts cycles with enable high; expired is
// raised combinationally in the wait cycle that would bring the count to
// TIMEOUT_CYCLES.
module mem_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Wait-cycle counter, saturating at the last value so it never wraps
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage with the MEM/WB register folded in.
// Runs one request/acknowledge data-bus transaction per load/store and
// stalls the pipeline until the bus answers. Optional bus-wait timeout is
// built when the macro MEM_TIMEOUT_EN is defined; otherwise the stage
// waits for the acknowledge indefinitely and mem_busError stays 0.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_memWriteEnable,
   input  logic                  mem_memReadEnable,
   input  logic [MEM_ADDR_W-1:0] mem_memAddr,
   input  logic [MEM_SEL_W-1:0]  mem_memSel,
   input  logic [WORD_W-1:0]     mem_result,
   input  logic [REG_ADDR_W-1:0] mem_regDest,
   input  logic                  mem_resultSel,
   output logic                  dbus_req,
   output logic                  dbus_we,
   output logic [MEM_ADDR_W-1:0] dbus_addr,
   output logic [MEM_SEL_W-1:0]  dbus_sel,
   output logic [WORD_W-1:0]     dbus_wdata,
   input  logic [WORD_W-1:0]     dbus_rdata,
   input  logic                  dbus_ack,
   output logic                  mem_stallReq,
   output logic [REG_ADDR_W-1:0] wb_regDest,
   output logic [WORD_W-1:0]     wb_result,
   output logic                  mem_busError
);

   mem_state_e    state;
   logic          mem_op;
   logic          timeout_expired;
   reg_addr_bus_t dest_q;
   logic          result_sel_q;

   // A store wins when both enables are set, so any enable starts a transaction
   assign mem_op = mem_memWriteEnable | mem_memReadEnable;

`ifdef MEM_TIMEOUT_EN
   logic start_busy;
   logic wait_cycle;

   assign start_busy = (state == MEM_STATE_IDLE) && mem_op;
   assign wait_cycle = (state == MEM_STATE_BUSY) && !dbus_ack;

   mem_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .enable (wait_cycle),
      .clear  (start_busy),
      .expired(timeout_expired)
   );
`else
   assign timeout_expired = 1'b0;
`endif

   // Stall upstream while a transaction is being issued or still outstanding
   always_comb begin
      mem_stallReq = 1'b0;
      case (state)
         MEM_STATE_IDLE: mem_stallReq = mem_op;
         MEM_STATE_BUSY: mem_stallReq = !dbus_ack && !timeout_expired;
         default:        mem_stallReq = 1'b0;
      endcase
   end

   // Transaction FSM with registered bus and writeback outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= MEM_STATE_IDLE;
         dbus_req     <= 1'b0;
         dbus_we      <= 1'b0;
         dbus_addr    <= '0;
         dbus_sel     <= '0;
         dbus_wdata   <= ZERO_WORD;
         wb_regDest   <= REG_ZERO;
         wb_result    <= ZERO_WORD;
         mem_busError <= 1'b0;
      end else begin
         mem_busError <= 1'b0;
         case (state)
            MEM_STATE_IDLE: begin
               if (mem_op) begin
                  dbus_req   <= 1'b1;
                  dbus_we    <= mem_memWriteEnable;
                  dbus_addr  <= mem_memAddr;
                  dbus_sel   <= mem_memSel;
                  dbus_wdata <= mem_result;
                  wb_regDest <= REG_ZERO;
                  state      <= MEM_STATE_BUSY;
               end else begin
                  wb_regDest <= mem_regDest;
                  wb_result  <= mem_result;
               end
            end
            MEM_STATE_BUSY: begin
               if (dbus_ack) begin
                  dbus_req <= 1'b0;
                  state    <= MEM_STATE_IDLE;
                  if (dbus_we) begin
                     wb_regDest <= REG_ZERO;
                     wb_result  <= ZERO_WORD;
                  end else begin
                     wb_regDest <= dest_q;
                     wb_result  <= (result_sel_q == MEM_SEL_MEMVAL) ? dbus_rdata : dbus_wdata;
                  end
               end else if (timeout_expired) begin
                  dbus_req     <= 1'b0;
                  state        <= MEM_STATE_IDLE;
                  wb_regDest   <= REG_ZERO;
                  mem_busError <= 1'b1;
               end
            end
            default: state <= MEM_STATE_IDLE;
         endcase
      end
   end

   // Writeback destination and source captured at issue; pure data, no reset
   always_ff @(posedge clk) begin
      if ((state == MEM_STATE_IDLE) && mem_op) begin
         dest_q       <= mem_regDest;
         result_sel_q <= mem_resultSel;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access (TIMEOUT_CYCLES = 4). The timeout
// scenario checks the expiry behaviour when MEM_TIMEOUT_EN is defined and
// checks that the stage keeps waiting when it is not.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        we, re;
   logic [29:0] addr;
   logic [3:0]  sel;
   logic [31:0] result;
   logic [4:0]  dest;
   logic        rsel;
   logic        dbus_req, dbus_we;
   logic [29:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        stall;
   logic [4:0]  wb_dest;
   logic [31:0] wb_res;
   logic        bus_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_memWriteEnable(we),
      .mem_memReadEnable (re),
      .mem_memAddr       (addr),
      .mem_memSel        (sel),
      .mem_result        (result),
      .mem_regDest       (dest),
      .mem_resultSel     (rsel),
      .dbus_req          (dbus_req),
      .dbus_we           (dbus_we),
      .dbus_addr         (dbus_addr),
      .dbus_sel          (dbus_sel),
      .dbus_wdata        (dbus_wdata),
      .dbus_rdata        (rdata),
      .dbus_ack          (ack),
      .mem_stallReq      (stall),
      .wb_regDest        (wb_dest),
      .wb_result         (wb_res),
      .mem_busError      (bus_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic w, input logic r, input logic [29:0] a, input logic [3:0] s,
                         input logic [31:0] res, input logic [4:0] d, input logic rs);
      we = w; re = r; addr = a; sel = s; result = res; dest = d; rsel = rs;
   endtask

   task automatic test_reset();
      rst = 1'b1; ack = 1'b0; rdata = '0;
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      step(); step();
      checks++; if (dbus_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0h expected 0", dbus_req); end
      checks++; if ({dbus_we, dbus_addr, dbus_sel, dbus_wdata} !== 67'd0) begin failures++; $display("FAIL reset_bus: got %0h expected 0", {dbus_we, dbus_addr, dbus_sel, dbus_wdata}); end
      checks++; if ({wb_dest, wb_res} !== 37'd0) begin failures++; $display("FAIL reset_wb: got %0h expected 0", {wb_dest, wb_res}); end
      checks++; if ({bus_err, stall} !== 2'b00) begin failures++; $display("FAIL reset_err_stall: got %0b expected 00", {bus_err, stall}); end
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      set_op(1'b0, 1'b0, 30'h5, 4'hF, 32'h0000_1234, 5'd5, 1'b0);
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL pass_stall: got %0b expected 0", stall); end
      step();
      checks++; if (wb_dest !== 5'd5 || wb_res !== 32'h1234) begin failures++; $display("FAIL pass_wb: got %0d/%0h expected 5/1234", wb_dest, wb_res); end
      checks++; if (dbus_req !== 1'b0) begin failures++; $display("FAIL pass_req: got %0b expected 0", dbus_req); end
      set_op(1'b0, 1'b0, 30'h0, 4'h0, 32'hFFFF_FFFF, 5'd31, 1'b1);
      step();
      checks++; if (wb_dest !== 5'd31 || wb_res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL pass_wb2: got %0d/%0h expected 31/ffffffff", wb_dest, wb_res); end
   endtask

   task automatic test_load_wait();
      int stall_cnt = 0;
      set_op(1'b0, 1'b1, 30'h40, 4'hF, 32'h55, 5'd8, 1'b1);
      rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) ack = 1'b1;
         #1;
         if (stall) stall_cnt++;
         if (i >= 1) begin
            checks++; if (dbus_req !== 1'b1 || dbus_we !== 1'b0 || dbus_addr !== 30'h40 || wb_dest !== 5'd0) begin failures++; $display("FAIL load_busy%0d: got req=%0b we=%0b addr=%0h wbd=%0d expected 1/0/40/0", i, dbus_req, dbus_we, dbus_addr, wb_dest); end
         end
         step();
      end
      ack = 1'b0;
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      checks++; if (stall_cnt != 4) begin failures++; $display("FAIL load_stall_cycles: got %0d expected 4", stall_cnt); end
      checks++; if (wb_dest !== 5'd8 || wb_res !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_wb: got %0d/%0h expected 8/deadbeef", wb_dest, wb_res); end
      checks++; if (dbus_req !== 1'b0) begin failures++; $display("FAIL load_req_drop: got %0b expected 0", dbus_req); end
   endtask

   task automatic test_load_regval();
      set_op(1'b0, 1'b1, 30'h7, 4'hF, 32'h0000_ABCD, 5'd3, 1'b0);
      rdata = 32'h1111_1111;
      step();
      ack = 1'b1;
      step();
      ack = 1'b0;
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      checks++; if (wb_dest !== 5'd3 || wb_res !== 32'hABCD) begin failures++; $display("FAIL load_regval_wb: got %0d/%0h expected 3/abcd", wb_dest, wb_res); end
   endtask

   task automatic test_store();
      set_op(1'b1, 1'b0, 30'h100, 4'b0011, 32'h0000_CAFE, 5'd9, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_addr !== 30'h100 || dbus_sel !== 4'b0011 || dbus_wdata !== 32'hCAFE) begin failures++; $display("FAIL store_bus%0d: got req=%0b we=%0b addr=%0h sel=%0b wd=%0h expected 1/1/100/0011/cafe", i, dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata); end
         checks++; if (wb_dest !== 5'd0) begin failures++; $display("FAIL store_wbd_busy%0d: got %0d expected 0", i, wb_dest); end
      end
      ack = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_ack_stall: got %0b expected 0", stall); end
      step();
      ack = 1'b0;
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      checks++; if (wb_dest !== 5'd0 || wb_res !== 32'd0 || dbus_req !== 1'b0) begin failures++; $display("FAIL store_done: got wbd=%0d wbr=%0h req=%0b expected 0/0/0", wb_dest, wb_res, dbus_req); end
   endtask

   task automatic test_both_enables();
      set_op(1'b1, 1'b1, 30'h20, 4'hF, 32'h0000_BEEF, 5'd7, 1'b1);
      step();
      checks++; if (dbus_we !== 1'b1 || dbus_wdata !== 32'hBEEF) begin failures++; $display("FAIL both_we: got we=%0b wd=%0h expected 1/beef", dbus_we, dbus_wdata); end
      ack = 1'b1; rdata = 32'h1234_5678;
      step();
      ack = 1'b0;
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      checks++; if (wb_dest !== 5'd0) begin failures++; $display("FAIL both_wbd: got %0d expected 0", wb_dest); end
   endtask

   task automatic test_back_to_back();
      set_op(1'b0, 1'b1, 30'h1, 4'hF, 32'h0, 5'd10, 1'b1);
      step();
      checks++; if (dbus_req !== 1'b1) begin failures++; $display("FAIL b2b_req0: got %0b expected 1", dbus_req); end
      ack = 1'b1; rdata = 32'h1111_1111;
      step();
      ack = 1'b0;
      set_op(1'b0, 1'b1, 30'h2, 4'hF, 32'h0, 5'd11, 1'b1);
      checks++; if (dbus_req !== 1'b0) begin failures++; $display("FAIL b2b_req1: got %0b expected 0", dbus_req); end
      checks++; if (wb_dest !== 5'd10 || wb_res !== 32'h1111_1111) begin failures++; $display("FAIL b2b_wb1: got %0d/%0h expected 10/11111111", wb_dest, wb_res); end
      step();
      checks++; if (dbus_req !== 1'b1 || dbus_addr !== 30'h2) begin failures++; $display("FAIL b2b_req2: got %0b/%0h expected 1/2", dbus_req, dbus_addr); end
      ack = 1'b1; rdata = 32'h2222_2222;
      step();
      ack = 1'b0;
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      checks++; if (wb_dest !== 5'd11 || wb_res !== 32'h2222_2222) begin failures++; $display("FAIL b2b_wb2: got %0d/%0h expected 11/22222222", wb_dest, wb_res); end
   endtask

   task automatic test_reset_busy();
      set_op(1'b0, 1'b0, '0, '0, 32'h0000_AAAA, 5'd6, 1'b0);
      step();
      set_op(1'b0, 1'b1, 30'h9, 4'hF, 32'h0, 5'd12, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_op(1'b0, 1'b0, '0, '0, 32'h77, 5'd4, 1'b0);
      checks++; if (dbus_req !== 1'b0 || wb_dest !== 5'd0 || wb_res !== 32'd0) begin failures++; $display("FAIL rstbusy_out: got req=%0b wbd=%0d wbr=%0h expected 0/0/0", dbus_req, wb_dest, wb_res); end
      ack = 1'b1; rdata = 32'h9999_9999;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL late_ack_stall: got %0b expected 0", stall); end
      step();
      ack = 1'b0;
      checks++; if (dbus_req !== 1'b0 || wb_dest !== 5'd4 || wb_res !== 32'h77) begin failures++; $display("FAIL late_ack_ignored: got req=%0b wbd=%0d wbr=%0h expected 0/4/77", dbus_req, wb_dest, wb_res); end
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      step();
   endtask

   task automatic test_timeout();
      set_op(1'b0, 1'b1, 30'h33, 4'hF, 32'h0, 5'd13, 1'b1);
      step();
`ifdef MEM_TIMEOUT_EN
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++; if (stall !== (i < 4) || bus_err !== 1'b0) begin failures++; $display("FAIL timeout_wait%0d: got stall=%0b err=%0b expected %0b/0", i, stall, bus_err, (i < 4)); end
         step();
      end
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      checks++; if (bus_err !== 1'b1 || dbus_req !== 1'b0 || wb_dest !== 5'd0) begin failures++; $display("FAIL timeout_expire: got err=%0b req=%0b wbd=%0d expected 1/0/0", bus_err, dbus_req, wb_dest); end
      step();
      checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse: got %0b expected 0", bus_err); end
`else
      for (int i = 1; i <= 6; i++) begin
         #1;
         checks++; if (stall !== 1'b1 || bus_err !== 1'b0 || dbus_req !== 1'b1) begin failures++; $display("FAIL wait_forever%0d: got stall=%0b err=%0b req=%0b expected 1/0/1", i, stall, bus_err, dbus_req); end
         step();
      end
      ack = 1'b1; rdata = 32'h0BAD_F00D;
      step();
      ack = 1'b0;
      set_op(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      checks++; if (wb_dest !== 5'd13 || wb_res !== 32'h0BAD_F00D) begin failures++; $display("FAIL wait_forever_wb: got %0d/%0h expected 13/badf00d", wb_dest, wb_res); end
`endif
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_load_wait();
      test_load_regval();
      test_store();
      test_both_enables();
      test_back_to_back();
      test_reset_busy();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register. It consumes that register's memory controls (read/write enables, word address, byte selects, result, destination, result select). It runs a request/acknowledge transaction on the data bus, stalls the pipeline until the bus responds, and registers the writeback value and destination for the WB stage (MEM/WB register folded in).

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: bus-wait cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_memWriteEnable  in  1  store request from EX/MEM
- mem_memReadEnable  in  1  load request from EX/MEM
- mem_memAddr  in  30  word address (byte address [31:2])
- mem_memSel  in  4  byte-lane enables
- mem_result  in  32  ALU result; for stores, the store data
- mem_regDest  in  5  destination register
- mem_resultSel  in  1  MEM_SEL_REGVAL (0) selects mem_result; MEM_SEL_MEMVAL (1) selects load data
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = write
- dbus_addr  out  30  word address
- dbus_sel  out  4  byte enables
- dbus_wdata  out  32  write data
- dbus_rdata  in  32  read data, valid when dbus_ack=1
- dbus_ack  in  1  one-cycle transaction completion
- mem_stallReq  out  1  combinational stall to pipeline control
- wb_regDest  out  5  writeback destination; 0 = no write
- wb_result  out  32  writeback value
- mem_busError  out  1  one-cycle timeout pulse (0 without MEM_TIMEOUT_EN)

## Operation
- States: IDLE, BUSY.
- IDLE, no memory op (both enables 0): next edge wb_regDest<=mem_regDest and wb_result<=mem_result. This is a plain pipeline register.
- IDLE with an op: mem_stallReq=1. Next edge:
  - dbus_req<=1.
  - dbus_we<=mem_memWriteEnable.
  - dbus_addr, dbus_sel and dbus_wdata<=mem_result are latched.
  - Internal copies of regDest and resultSel are latched.
  - wb_regDest<=0.
  - State goes to BUSY.
- Both enables high: treated as a write.
- BUSY: bus outputs held stable; mem_stallReq = !dbus_ack. On ack edge:
  - dbus_req<=0, state goes to IDLE.
  - Load: wb_result<=dbus_rdata if latched resultSel=MEMVAL, else the latched result; wb_regDest<=latched regDest.
  - Store: wb_regDest<=0, wb_result<=0.
- Upstream holds EX/MEM inputs stable while mem_stallReq=1. The instruction following the memory op is accepted at the ack edge and handled from IDLE on the next cycle.
- dbus_ack in IDLE is ignored.
- Full 32-bit words only; no byte/half extraction or sign extension (done in WB).

## Timing
- Reset values: state IDLE; dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata = 0; wb_regDest, wb_result = 0; mem_busError = 0.
- Non-memory op: 1-cycle latency, no stall.
- Memory op: request visible 1 cycle after acceptance. Ack in the first BUSY cycle gives a 2-cycle occupancy. Each extra wait cycle adds 1.
- rst in BUSY: return to IDLE, dbus_req=0 next edge, no writeback, a late ack is ignored.
- Back-to-back memory ops: 1 IDLE cycle between transactions (req low for exactly one cycle).

## Configuration
- MEM_TIMEOUT_EN defined: a counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack: dbus_req<=0, state goes to IDLE, wb_regDest<=0, mem_busError pulses 1 cycle, and stall releases that cycle.
  - Ack arriving in the same cycle as expiry wins.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely, no counter logic, mem_busError tied 0.

## Structure
- Shared define file:
  - MEM_SEL_REGVAL/MEM_SEL_MEMVAL
  - WORD_BUS, REG_ADDR_BUS, MEM_ADDR_HIGH_BUS, MEM_SEL_BUS
  - REG_ZERO, ZERO_WORD
  - state encodings MEM_STATE_IDLE/MEM_STATE_BUSY
- Optional sub-module mem_timeout_counter (enable, clear, expired), instantiated only under MEM_TIMEOUT_EN.

## Test plan
- ALU passthrough: regDest=5, result=0x1234, enables 0 -> next cycle wb_regDest=5, wb_result=0x1234, stall never asserted.
- Load, ack after 3 BUSY cycles, rdata=0xDEADBEEF, regDest=8, resultSel=1 -> stall for 4 cycles, then wb_regDest=8, wb_result=0xDEADBEEF.
- Store addr=0x100, sel=4'b0011, data=0xCAFE -> dbus_we=1, dbus_addr=0x100, dbus_sel=0011, dbus_wdata=0xCAFE held until ack; wb_regDest=0.
- Two consecutive loads, ack on first BUSY cycle -> dbus_req pattern 1,0,1; both writebacks correct and in order.
- rst asserted during BUSY, then ack -> dbus_req=0 after the edge, wb outputs 0, ack ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_busError pulse after 4 BUSY cycles, stall released, wb_regDest=0.
